// File: rtl/ctx_pkt_arb4.sv
// ---------------------------------------------------------------------------
// ctx_pkt_arb4 -- four-input packet arbiter / merger
//
// Merges four 36-bit packet streams onto one output stream, one whole packet
// at a time. Word format: [31:0] payload, [32] SOF, [33] EOF, [35:34] occupancy.
// Arbitration is round-robin over inputs presenting SOF. With PRIO0=1, input 0
// pre-empts the round-robin whenever it presents SOF.
//
// Build option:
//   CTX_ARB_WATCHDOG_EN  when defined, adds the mid-packet stall watchdog:
//                        stall counter, ABORT state (emits an EOF-only word),
//                        per-input drop flags and the sticky timeout bit.
//                        When undefined, PASS waits indefinitely for the
//                        granted source and TIMEOUT has no effect.
//
// Parameters:
//   PRIO0    0: plain round-robin; 1: input 0 has strict priority
//   TIMEOUT  stall limit in cycles (1..1023), watchdog builds only
//
// Ports:
//   clk                  rising-edge clock
//   reset                synchronous active-high reset
//   clear                synchronous abort; like reset but keeps status[6:5]
//   data0_i..data3_i     input packet streams
//   src0_rdy_i..3        input word valid
//   dst0_rdy_o..3        input word accepted this cycle
//   data_o               merged output stream
//   src_rdy_o            data_o valid
//   dst_rdy_i            downstream ready
//   status               [3:0] one-hot grant, [4] busy, [5] sticky orphan,
//                        [6] sticky timeout, [7] zero
// ---------------------------------------------------------------------------
module ctx_pkt_arb4 #(
  parameter int unsigned PRIO0   = 0,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [35:0] data0_i,
  input  logic [35:0] data1_i,
  input  logic [35:0] data2_i,
  input  logic [35:0] data3_i,
  input  logic        src0_rdy_i,
  input  logic        src1_rdy_i,
  input  logic        src2_rdy_i,
  input  logic        src3_rdy_i,
  output logic        dst0_rdy_o,
  output logic        dst1_rdy_o,
  output logic        dst2_rdy_o,
  output logic        dst3_rdy_o,
  output logic [35:0] data_o,
  output logic        src_rdy_o,
  input  logic        dst_rdy_i,
  output logic [7:0]  status
);

  if (TIMEOUT < 1 || TIMEOUT > 1023) begin : g_bad_timeout
    $error("ctx_pkt_arb4: TIMEOUT must be in 1..1023");
  end

  localparam int SOF_BIT = 32;
  localparam int EOF_BIT = 33;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PICK,
    ST_PASS
`ifdef CTX_ARB_WATCHDOG_EN
    ,
    ST_ABORT
`endif
  } state_t;

  // Round-robin search: first requester at last+1, last+2, last+3, last.
  // Iterating from the farthest candidate down lets the nearest one win.
  function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                         input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = last + 2'd1;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

  // -------------------------------------------------------------------------
  // Input bundling
  // -------------------------------------------------------------------------
  logic [35:0] din [4];
  logic [3:0]  srdy;
  logic [3:0]  sof;
  logic [3:0]  eof;
  logic [3:0]  drdy;
  logic [3:0]  drop_act;
  logic [3:0]  req;

  assign din[0] = data0_i;
  assign din[1] = data1_i;
  assign din[2] = data2_i;
  assign din[3] = data3_i;
  assign srdy   = {src3_rdy_i, src2_rdy_i, src1_rdy_i, src0_rdy_i};

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      sof[n] = din[n][SOF_BIT];
      eof[n] = din[n][EOF_BIT];
    end
  end

  assign dst0_rdy_o = drdy[0];
  assign dst1_rdy_o = drdy[1];
  assign dst2_rdy_o = drdy[2];
  assign dst3_rdy_o = drdy[3];

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t     state, state_nxt;
  logic [1:0] grant, grant_nxt;
  logic [1:0] last_grant, last_nxt;
  logic [1:0] win;
  logic       orphan_sticky;
  logic       orphan_set;
  logic       timeout_flag;
  logic       xfer;
  logic       busy;

`ifdef CTX_ARB_WATCHDOG_EN
  localparam logic [35:0] ABORT_WORD = 36'h2_0000_0000;

  logic [9:0] stall_cnt, stall_nxt;
  logic [3:0] drop, drop_nxt;
  logic       timeout_sticky;
  logic       timeout_set;

  assign drop_act     = drop;
  assign timeout_flag = timeout_sticky;
`else
  assign drop_act     = 4'b0000;
  assign timeout_flag = 1'b0;
`endif

  // Inputs under a drop flag never compete for the output.
  assign req = srdy & sof & ~drop_act;

  always_comb begin
    win = rr_pick(req, last_grant);
    if (PRIO0 != 0 && req[0]) win = 2'd0;
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case/if tree can leave one unassigned and infer a latch.
    state_nxt  = state;
    grant_nxt  = grant;
    last_nxt   = last_grant;
    orphan_set = 1'b0;
    drdy       = 4'b0000;
    data_o     = '0;
    src_rdy_o  = 1'b0;
    xfer       = 1'b0;
`ifdef CTX_ARB_WATCHDOG_EN
    stall_nxt   = stall_cnt;
    drop_nxt    = drop;
    timeout_set = 1'b0;
`endif

    unique case (state)
      ST_IDLE: begin
        // Discard dropped words and orphans (non-SOF words between packets).
        // A drop flag masks the orphan condition on the same input.
        for (int n = 0; n < 4; n++) begin
          if (srdy[n]) begin
            if (drop_act[n]) begin
              drdy[n] = 1'b1;
            end else if (!sof[n]) begin
              drdy[n]    = 1'b1;
              orphan_set = 1'b1;
            end
          end
        end
`ifdef CTX_ARB_WATCHDOG_EN
        for (int n = 0; n < 4; n++) begin
          if (drop[n] && srdy[n] && eof[n]) drop_nxt[n] = 1'b0;
        end
`endif
        if (|req) begin
          grant_nxt = win;
          state_nxt = ST_PICK;
        end
      end

      ST_PICK: begin
        state_nxt = ST_PASS;
      end

      ST_PASS: begin
        src_rdy_o   = srdy[grant];
        data_o      = din[grant];
        drdy[grant] = dst_rdy_i;
        xfer        = srdy[grant] & dst_rdy_i;
        if (xfer && eof[grant]) begin
          last_nxt  = grant;
          state_nxt = ST_IDLE;
        end
`ifdef CTX_ARB_WATCHDOG_EN
        // Only a silent source counts as a stall; downstream backpressure
        // with the source still valid holds the count.
        if (xfer) begin
          stall_nxt = '0;
        end else if (!srdy[grant]) begin
          stall_nxt = stall_cnt + 10'd1;
          if (stall_nxt == 10'(TIMEOUT)) state_nxt = ST_ABORT;
        end
`endif
      end

`ifdef CTX_ARB_WATCHDOG_EN
      ST_ABORT: begin
        // Terminate the downstream packet with an EOF-only word, then drop
        // the rest of the stalled input's packet.
        src_rdy_o = 1'b1;
        data_o    = ABORT_WORD;
        if (dst_rdy_i) begin
          timeout_set    = 1'b1;
          drop_nxt[grant] = 1'b1;
          last_nxt       = grant;
          state_nxt      = ST_IDLE;
        end
      end
`endif

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

`ifdef CTX_ARB_WATCHDOG_EN
    if (state_nxt != ST_PASS) stall_nxt = '0;
`endif
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order the statements run in.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state      <= ST_IDLE;
      grant      <= 2'd0;
      last_grant <= 2'd3;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_nxt;
    end
  end

  // Sticky status survives clear; only reset wipes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      orphan_sticky <= 1'b0;
    end else if (!clear && orphan_set) begin
      orphan_sticky <= 1'b1;
    end
  end

`ifdef CTX_ARB_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      stall_cnt <= '0;
      drop      <= 4'b0000;
    end else begin
      stall_cnt <= stall_nxt;
      drop      <= drop_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_sticky <= 1'b0;
    end else if (!clear && timeout_set) begin
      timeout_sticky <= 1'b1;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Status
  // -------------------------------------------------------------------------
  assign busy   = (state != ST_IDLE);
  assign status = {1'b0, timeout_flag, orphan_sticky, busy,
                   busy ? (4'b0001 << grant) : 4'b0000};

endmodule
